// File: rtl/serial_slave_port_if.sv
// Serial bus lines shared by the external master and one slave endpoint.
interface serial_slave_port_if;
  logic control;
  logic wD;
  logic valid;
  logic rD;
  logic ready;

  modport master (output control, output wD, output valid, input rD, input ready);
  modport slave  (input control, input wD, input valid, output rD, output ready);
endinterface

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: frame decode, write deserializer, read serializer.
// Optional even-parity per word on wD/rD enabled by `define SERIAL_SLAVE_PARITY_EN.
module serial_slave_port #(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 12,
  parameter logic [1:0] SLAVEID    = 2'd1
) (
  input  logic                  clk,
  input  logic                  rstN,
  serial_slave_port_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CLEN    = 4 + ADDR_WIDTH;
  localparam int WLEN    = DATA_WIDTH + PAR;
  localparam int RLEN    = DATA_WIDTH + PAR;
  localparam int CNT_MAX = (CLEN > WLEN) ? CLEN : WLEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL, S_WR_DATA, S_WR_COMMIT, S_RD_FETCH, S_RD_WAIT, S_RD_SHIFT
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ones_q, ones_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CLEN-2:0]         ctl_q, ctl_d;
  logic                    burst_q, burst_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wsh_q, wsh_d;
  logic [RLEN-1:0]         rsh_q, rsh_d;
  logic                    rd_q, rd_d;
  logic                    ready_q, ready_d;
  logic                    we_q, we_d;
  logic                    re_q, re_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;

  logic [CLEN-1:0]         frame;
  logic [RLEN-1:0]         load;
  logic                    par_ok;

  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
      burst_q <= 1'b0;
      addr_q  <= '0;
      wsh_q   <= '0;
      rsh_q   <= '0;
      rd_q    <= 1'b0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      wsh_q   <= wsh_d;
      rsh_q   <= rsh_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      re_q    <= re_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    wsh_d   = wsh_q;
    rsh_d   = rsh_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    we_d    = 1'b0;
    frame   = {ctl_q, bus.control};
    par_ok  = 1'b1;
`ifdef SERIAL_SLAVE_PARITY_EN
    load    = {mem_rdata, ^mem_rdata};
`else
    load    = mem_rdata;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.control) begin
          if (ones_q == 2'd2) begin
            ones_d  = '0;
            cnt_d   = '0;
            state_d = S_CTRL;
          end else begin
            ones_d = ones_q + 2'd1;
          end
        end else begin
          ones_d = '0;
        end
      end
      S_CTRL: begin
        ctl_d = frame[CLEN-2:0];
        if (cnt_q == CNT_W'(CLEN - 1)) begin
          cnt_d = '0;
          if (frame[ADDR_WIDTH+3 -: 2] != SLAVEID) begin
            state_d = S_IDLE;
          end else begin
            burst_d = frame[ADDR_WIDTH];
            addr_d  = frame[ADDR_WIDTH-1:0];
            state_d = frame[ADDR_WIDTH+1] ? S_WR_DATA : S_RD_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_DATA: begin
        if (bus.valid) begin
          if (cnt_q < CNT_W'(DATA_WIDTH))
            wsh_d = {wsh_q[DATA_WIDTH-2:0], bus.wD};
          if (cnt_q == CNT_W'(WLEN - 1)) begin
            cnt_d   = '0;
            state_d = S_WR_COMMIT;
`ifdef SERIAL_SLAVE_PARITY_EN
            // the data word is complete in wsh_q; this last bit is parity
            wdata_d = wsh_q;
            par_ok  = ~(^{wsh_q, bus.wD});
            err_d   = err_q | ~par_ok;
`else
            wdata_d = {wsh_q[DATA_WIDTH-2:0], bus.wD};
`endif
            we_d    = par_ok;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WR_COMMIT: begin
        if (burst_q && bus.valid) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_WR_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_FETCH: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_d    = load[RLEN-1];
        rsh_d   = load << 1;
        cnt_d   = '0;
        state_d = S_RD_SHIFT;
      end
      S_RD_SHIFT: begin
        if (cnt_q == CNT_W'(RLEN - 1)) begin
          cnt_d = '0;
          if (burst_q && bus.valid) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_RD_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          rd_d  = rsh_q[RLEN-1];
          rsh_d = rsh_q << 1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered, so they are derived from the state being entered
    re_d    = (state_d == S_RD_FETCH);
    ready_d = !(state_d inside {S_WR_COMMIT, S_RD_FETCH, S_RD_WAIT});
  end

  assign bus.rD    = rd_q;
  assign bus.ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign err       = err_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Randomized scoreboard bench for serial_slave_port with a reference memory model.
module tb_serial_slave_port;
  localparam int DW = 8;
  localparam int AW = 12;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int RLEN = DW + PAR;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  serial_slave_port_if bus();
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_we, mem_re, err;

  serial_slave_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVEID(2'd1)) dut (
    .clk(clk), .rstN(rstN), .bus(bus),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .err(err)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [DW-1:0] tb_mem  [1<<AW];
  bit [DW-1:0] ref_mem [1<<AW];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= tb_mem[mem_addr];
  end

  typedef struct {
    bit          wr;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  bit exp_err = 1'b0;
  bit [DW-1:0] wbuf [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [RLEN-1:0] exp_word(input bit [DW-1:0] d);
`ifdef SERIAL_SLAVE_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT strobes the memory port
  exp_t e;
  bit rd_on = 1'b0;
  int unsigned rd_base;
  logic [RLEN-1:0] rd_word, rd_exp;
  always @(negedge clk) begin
    if (rstN) begin
      rd_on = 1'b0;
    end else begin
      if (mem_we) begin
        if (exp_q.size() == 0 || !exp_q[0].wr) begin
          check("we_unexpected", mem_we, 0);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", mem_addr, e.addr);
          check("we_data", mem_wdata, e.data);
          check("we_cycle", cyc, e.cyc);
          check("we_ready", bus.ready, 0);
        end
      end
      if (mem_re) begin
        if (exp_q.size() == 0 || exp_q[0].wr) begin
          check("re_unexpected", mem_re, 0);
        end else begin
          e = exp_q.pop_front();
          check("re_addr", mem_addr, e.addr);
          check("re_cycle", cyc, e.cyc);
          check("re_ready", bus.ready, 0);
          rd_on   = 1'b1;
          rd_base = cyc;
          rd_exp  = exp_word(e.data);
          rd_word = '0;
        end
      end else if (rd_on) begin
        if (cyc == rd_base + 1) begin
          check("rd_wait_ready", bus.ready, 0);
          check("rd_wait_rD", bus.rD, 0);
        end else begin
          rd_word = {rd_word[RLEN-2:0], bus.rD};
          check("rd_shift_ready", bus.ready, 1);
          if (cyc == rd_base + 1 + RLEN) begin
            check("rd_word", rd_word, rd_exp);
            rd_on = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.control = 1'b0;
    bus.valid   = 1'b0;
    bus.wD      = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_frame(input bit [1:0] id, input bit rw, input bit b, input bit [AW-1:0] addr);
    logic [AW+6:0] f;
    f = {3'b111, id, rw, b, addr};
    for (int i = AW + 6; i >= 0; i--) begin
      bus.control = f[i];
      bus.valid   = 1'($urandom_range(0, 1));
      bus.wD      = 1'($urandom_range(0, 1));
      step();
    end
    bus.control = 1'b0;
    bus.valid   = 1'b0;
  endtask

  task automatic pause(input int n);
    repeat (n) begin
      bus.valid = 1'b0;
      bus.wD    = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // pause_mode: 0 none, 1 random gaps, 2 three-cycle gap after 4 bits of word 0
  task automatic do_write(input bit [1:0] id, input bit b, input bit [AW-1:0] addr,
                          input int n, input int pause_mode, input bit bad_par);
    bit [AW-1:0] a;
    send_frame(id, 1'b1, b, addr);
    if (id != 2'd1) begin
      idle(4);
      return;
    end
    for (int k = 0; k < n; k++) begin
      a = addr + AW'(k);
      for (int i = DW - 1; i >= 0; i--) begin
        if (pause_mode == 1 && $urandom_range(0, 3) == 0) pause(int'($urandom_range(1, 2)));
        if (pause_mode == 2 && k == 0 && i == DW - 5) pause(3);
        bus.valid = 1'b1;
        bus.wD    = wbuf[k][i];
        step();
      end
      if (PAR == 1) begin
        bus.valid = 1'b1;
        bus.wD    = (^wbuf[k]) ^ bad_par;
        step();
      end
      if (PAR == 1 && bad_par) begin
        exp_err = 1'b1;
      end else begin
        exp_q.push_back('{wr: 1'b1, addr: a, data: wbuf[k], cyc: cyc});
        ref_mem[a] = wbuf[k];
      end
      bus.valid = b && (k < n - 1);
      bus.wD    = 1'($urandom_range(0, 1));
      step();
    end
    bus.valid = 1'b0;
  endtask

  task automatic do_read(input bit [1:0] id, input bit b, input bit [AW-1:0] addr, input int n);
    int unsigned t;
    bit [AW-1:0] a;
    send_frame(id, 1'b0, b, addr);
    t = cyc;
    if (id != 2'd1) begin
      idle(4);
      return;
    end
    for (int k = 0; k < n; k++) begin
      a = addr + AW'(k);
      exp_q.push_back('{wr: 1'b0, addr: a, data: ref_mem[a], cyc: t + k * (RLEN + 2)});
    end
    for (int k = 0; k < n; k++) begin
      repeat (RLEN + 1) begin
        bus.valid = 1'($urandom_range(0, 1));
        bus.wD    = 1'($urandom_range(0, 1));
        step();
      end
      bus.valid = b ? (k < n - 1) : 1'($urandom_range(0, 1));
      step();
    end
    bus.valid = 1'b0;
  endtask

  initial begin
    bit [1:0] id;
    bit [AW-1:0] addr;
    int n;
    bit b;
    bus.control = 1'b0;
    bus.valid   = 1'b0;
    bus.wD      = 1'b0;
    rstN = 1'b1;
    step();
    step();
    check("rst_rD", bus.rD, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_err", err, 0);
    rstN = 1'b0;
    idle(2);

    // reset after 4 of 8 data bits
    send_frame(2'd1, 1'b1, 1'b0, 12'h0A5);
    repeat (4) begin
      bus.valid = 1'b1;
      bus.wD    = 1'($urandom_range(0, 1));
      step();
    end
    rstN = 1'b1;
    step();
    rstN = 1'b0;
    bus.valid = 1'b0;
    check("midrst_ready", bus.ready, 1);
    check("midrst_rD", bus.rD, 0);
    check("midrst_we", mem_we, 0);
    idle(3);

    wbuf[0] = 8'hCC;
    do_write(2'd1, 1'b0, 12'h0A5, 1, 0, 1'b0);
    idle(3);

    // ID mismatch: bus activity must not reach memory
    send_frame(2'd2, 1'b1, 1'b0, 12'h0A5);
    for (int i = 0; i < 12; i++) begin
      bus.valid = 1'b1;
      bus.wD    = 1'($urandom_range(0, 1));
      step();
      check("idmis_ready", bus.ready, 1);
    end
    idle(3);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(2'd1, 1'b1, 12'hFFF, 2, 2, 1'b0);
    idle(3);

    wbuf[0] = 8'h3C;
    do_write(2'd1, 1'b0, 12'h010, 1, 0, 1'b0);
    idle(2);
    do_read(2'd1, 1'b0, 12'h010, 1);
    idle(3);
    do_read(2'd1, 1'b1, 12'hFFF, 2);
    idle(3);

`ifdef SERIAL_SLAVE_PARITY_EN
    wbuf[0] = 8'hCC;
    do_write(2'd1, 1'b0, 12'h020, 1, 0, 1'b1);
    idle(2);
    check("par_err_set", err, 1);
    wbuf[0] = 8'h5A;
    do_write(2'd1, 1'b0, 12'h020, 1, 0, 1'b0);
    idle(2);
    check("par_err_sticky", err, 1);
`endif

    for (int t = 0; t < 40; t++) begin
      id   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      addr = ($urandom_range(0, 3) == 0) ? AW'(12'hFFE + $urandom_range(0, 1)) : AW'($urandom);
      n    = int'($urandom_range(1, 3));
      b    = (n > 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = DW'($urandom);
        do_write(id, b, addr, n, 1, 1'b0);
      end else begin
        do_read(id, b, addr, n);
      end
      idle(int'($urandom_range(0, 3)));
    end

    idle(20);
    check("queue_empty", exp_q.size(), 0);
    check("err_final", err, exp_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Slave-side endpoint of the serial bus driven by the external master. It decodes the serial control frame (start | slave ID | R/W | burst | start address) and deserializes `wD` write words into a local memory port. It also fetches read words and serializes them back on `rD`. It sits between the bus lines (`control`, `wD`, `valid`, `rD`, `ready`) and a slave's memory or register bank, and can be instantiated once per slave behind the bus.

## Interface
- `DATA_WIDTH`, 8, word width on wD/rD and memory port
- `ADDR_WIDTH`, 12, start-address width in control frame and memory address width
- `SLAVEID`, 2'd1, 2-bit ID this port answers to
- `clk`  in  1  system clock, all logic on rising edge
- `rstN`  in  1  reset; **synchronous, active-high** (bus-wide port name kept)
- `control`  in  1  serial control frame from master, MSB first
- `wD`  in  1  serial write data, MSB first
- `valid`  in  1  qualifies `wD` bits; word-boundary continue flag in bursts
- `rD`  out  1  serial read data, MSB first
- `ready`  out  1  slave status (see Operation)
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  write word
- `mem_we`  out  1  one-cycle write strobe
- `mem_re`  out  1  one-cycle read strobe
- `mem_rdata`  in  DATA_WIDTH  read word, valid the cycle after `mem_re`
- `err`  out  1  sticky parity error (only with macro, else constant 0)

## Operation
- Reset values: `rD`=0, `ready`=1, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0; state IDLE, all counters 0.
- Control frame format: `111`, then ID[1:0], then RW (1=write, 0=read), then B (1=burst), then ADDR[ADDR_WIDTH-1:0]. Length is 7+ADDR_WIDTH bits.
- States:
  - IDLE: count consecutive 1s on `control`. The third 1 moves to CTRL. A 0 clears the count.
  - CTRL: shift 4+ADDR_WIDTH bits. On the last bit:
    - ID≠SLAVEID → IDLE, no memory access.
    - RW=1 → WR_DATA.
    - RW=0 → RD_FETCH.
  - WR_DATA: shift `wD` only on cycles with `valid`=1. `valid`=0 pauses with no bit lost. After DATA_WIDTH bits → WR_COMMIT.
  - WR_COMMIT (1 cycle): `mem_we`=1, `mem_addr`=current address, `ready`=0.
    - B=1 and `valid`=1 this cycle → address+1, back to WR_DATA.
    - Otherwise → IDLE.
  - RD_FETCH (1 cycle): `mem_re`=1, `ready`=0.
  - RD_WAIT (1 cycle): `ready`=0, capture `mem_rdata` into the shift register.
  - RD_SHIFT: DATA_WIDTH cycles with `ready`=1, `rD`=MSB first. On the last bit:
    - B=1 and `valid`=1 → address+1, RD_FETCH.
    - Otherwise → IDLE.
- `ready`=1 in IDLE, CTRL, WR_DATA, RD_SHIFT. `ready`=0 in WR_COMMIT, RD_FETCH, RD_WAIT.
- `rD`=0 outside RD_SHIFT.
- Address increments modulo 2^ADDR_WIDTH: 0xFFF+1 → 0x000 at default width.
- `control` is ignored outside IDLE/CTRL. A new frame only starts from IDLE.
- `valid` outside WR_DATA/WR_COMMIT/last RD_SHIFT bit is ignored.
- `rstN` high in any state → IDLE on that edge. A partial word is discarded with no `mem_we`, and `err` clears.

## Timing
- Control frame last bit sampled at edge T.
- Write, single word: with `valid` continuously high from T+1, bits are sampled at T+1..T+DATA_WIDTH and `mem_we` is high in cycle T+DATA_WIDTH+1.
- Read: `mem_re` in cycle T+1, capture at T+2, first `rD` bit (MSB) in cycle T+3. Burst words are separated by 2 `ready`-low cycles.
- All outputs are registered. There are no combinational paths from bus inputs to outputs.

## Configuration
- `SERIAL_SLAVE_PARITY_EN` defined:
  - Each write word carries one extra even-parity bit on `wD` after the LSB, so WR_DATA takes DATA_WIDTH+1 valid bits.
  - On mismatch, WR_COMMIT still occurs (`ready`=0, burst rules unchanged), but `mem_we` stays 0 and `err` sets.
  - `err` clears only on reset.
  - Read words gain one even-parity bit on `rD` after the LSB, so RD_SHIFT lasts DATA_WIDTH+1 cycles.
- Macro undefined: no parity bits, `err` tied 0.

## Test plan
- Reset mid-write: reset asserted after 4 of 8 data bits → no `mem_we`, `ready`=1, `rD`=0 next cycle. A following full frame works normally.
- Single write: frame `111`,ID=01,RW=1,B=0,ADDR=0x0A5, then `wD`=0xCC with `valid` high → one `mem_we` at addr 0x0A5 with data 0xCC, exactly 9 cycles after the last control bit, then IDLE.
- ID mismatch: same frame with ID=10 → no `mem_we`/`mem_re`, `ready` stays 1.
- Burst write with pause and wrap: ADDR=0xFFF, words 0x11, 0x22, with `valid` low for 3 cycles mid-first-word → writes 0x11@0xFFF and 0x22@0x000. Burst ends when `valid`=0 at the second commit.
- Single read: `mem_rdata`=0x3C at 0x010 → `mem_re` at T+1, `ready` low for T+1..T+2, `rD` sequence 0,0,1,1,1,1,0,0 on T+3..T+10.
- Parity (macro on): write 0xCC with parity bit 1 → no `mem_we`, `err`=1 and stays 1. A correct-parity write then commits while `err` stays 1.
